// File: rtl/tcam_pkg.sv
// Purpose: shared TCAM command encodings and scheduler FSM state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tcam_pkg;

    // Command presented on tcam_mode each cycle.
    typedef enum logic [2:0] {
        MODE_I   = 3'b000,  // idle / no-op
        MODE_W   = 3'b001,  // write entry
        MODE_R   = 3'b010,  // read entry payload
        MODE_C   = 3'b100,  // compare key against all entries
        MODE_RST = 3'b101   // array reset
    } tcam_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_CMP,
        ST_CMP_WAIT,
        ST_SCAN,
        ST_RD,
        ST_RD_WAIT,
        ST_OUT
    } sched_state_e;

    // Wide enough for any practical compare/read latency.
    localparam int CNT_W = 8;

endpackage

// File: rtl/tcam_prio_enc.sv
// Purpose: lowest-set-bit priority encoder over a TCAM hit vector.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   vec_i  Words        hit vector
//   idx_o  AddressSize  index of lowest set bit (0 when none set)
//   any_o  1            at least one bit set
module tcam_prio_enc #(
    parameter int Words       = 16,
    parameter int AddressSize = 4
) (
    input  logic [Words-1:0]       vec_i,
    output logic [AddressSize-1:0] idx_o,
    output logic                   any_o
);

    // Walk from the top down so the lowest set bit is the last to win.
    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        for (int i = Words - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = AddressSize'(i);
            end
        end
    end

endmodule

// File: rtl/tcam_spike_sched.sv
// Purpose: turns a fired spike ID into one synapse event per matching TCAM entry.
// Latency: first event 1+CMP_LAT+1+1+RD_LAT+1 cycles after spike accept; 3+RD_LAT between events.
// Backpressure: syn_ready low stalls in OUT with syn_* held; no new spike/cfg until scan ends.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   spk_valid/spk_ready, spk_id        spike input handshake and packet ID
//   cfg_valid/cfg_ready, cfg_addr/data/mskb   entry-program handshake
//   syn_valid/syn_ready, syn_dst/weight/addr  synapse-event output handshake
//   tcam_mode/data/mskb/a/vbe/vbi      registered TCAM command bus
//   tcam_hitline, tcam_dst/weight      TCAM compare and read results
//   busy                               high whenever the FSM is not IDLE
module tcam_spike_sched
    import tcam_pkg::*;
#(
    parameter int ID_Width     = 4,
    parameter int AddressSize  = 4,
    parameter int Words        = 16,
    parameter int Bits         = 8,
    parameter int Weight_Width = 4,
    parameter int CMP_LAT      = 2,
    parameter int RD_LAT       = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    spk_valid,
    output logic                    spk_ready,
    input  logic [ID_Width-1:0]     spk_id,

    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [AddressSize-1:0]  cfg_addr,
    input  logic [Bits-1:0]         cfg_data,
    input  logic [Bits-1:0]         cfg_mskb,

    output logic                    syn_valid,
    input  logic                    syn_ready,
    output logic [ID_Width-1:0]     syn_dst,
    output logic [Weight_Width-1:0] syn_weight,
    output logic [AddressSize-1:0]  syn_addr,

    output logic [2:0]              tcam_mode,
    output logic [Bits-1:0]         tcam_data,
    output logic [Bits-1:0]         tcam_mskb,
    output logic [AddressSize-1:0]  tcam_a,
    output logic                    tcam_vbe,
    output logic                    tcam_vbi,
    input  logic [Words-1:0]        tcam_hitline,
    input  logic [ID_Width-1:0]     tcam_dst,
    input  logic [Weight_Width-1:0] tcam_weight,

    output logic                    busy
);

    sched_state_e              state_q;
    tcam_mode_e                tcam_mode_q;
    logic [AddressSize-1:0]    tcam_a_q;
    logic [Bits-1:0]           tcam_data_q;
    logic [Bits-1:0]           tcam_mskb_q;
    logic                      tcam_vbe_q;
    logic                      tcam_vbi_q;
    logic [Words-1:0]          hit_vec_q;
    logic [AddressSize-1:0]    cur_addr_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      syn_valid_q;
    logic [ID_Width-1:0]       syn_dst_q;
    logic [Weight_Width-1:0]   syn_weight_q;
    logic [AddressSize-1:0]    syn_addr_q;
    logic                      rst_seen_q;

    logic [AddressSize-1:0]    prio_idx;
    logic                      prio_any;
    logic                      idle_rdy;

    tcam_prio_enc #(
        .Words       (Words),
        .AddressSize (AddressSize)
    ) u_prio_enc (
        .vec_i (hit_vec_q),
        .idx_o (prio_idx),
        .any_o (prio_any)
    );

    // The array-reset command is still on the bus during the first cycle after
    // reset release, so intake stays closed until tcam_mode has left RST.
    assign idle_rdy  = (state_q == ST_IDLE) && (tcam_mode_q != MODE_RST);
    assign cfg_ready = idle_rdy;
    assign spk_ready = idle_rdy;
    assign busy      = (state_q != ST_IDLE);

    assign tcam_mode  = tcam_mode_q;
    assign tcam_data  = tcam_data_q;
    assign tcam_mskb  = tcam_mskb_q;
    assign tcam_a     = tcam_a_q;
    assign tcam_vbe   = tcam_vbe_q;
    assign tcam_vbi   = tcam_vbi_q;

    assign syn_valid  = syn_valid_q;
    assign syn_dst    = syn_dst_q;
    assign syn_weight = syn_weight_q;
    assign syn_addr   = syn_addr_q;

    // TCAM command outputs are registered: each state's command is loaded on
    // the transition into that state and falls back to idle one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tcam_mode_q  <= MODE_RST;
            tcam_a_q     <= '0;
            tcam_data_q  <= '0;
            tcam_mskb_q  <= '0;
            tcam_vbe_q   <= 1'b0;
            tcam_vbi_q   <= 1'b0;
            hit_vec_q    <= '0;
            cur_addr_q   <= '0;
            cnt_q        <= '0;
            syn_valid_q  <= 1'b0;
            syn_dst_q    <= '0;
            syn_weight_q <= '0;
            syn_addr_q   <= '0;
            rst_seen_q   <= 1'b0;
        end else begin
            tcam_mode_q <= MODE_I;
            tcam_a_q    <= '0;
            tcam_data_q <= '0;
            tcam_mskb_q <= '0;
            tcam_vbe_q  <= 1'b0;
            tcam_vbi_q  <= 1'b0;

            if (!rst_seen_q) begin
                // Hold the array-reset command for one full cycle after release.
                rst_seen_q  <= 1'b1;
                tcam_mode_q <= MODE_RST;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (idle_rdy && cfg_valid) begin
                            state_q     <= ST_WR;
                            tcam_mode_q <= MODE_W;
                            tcam_a_q    <= cfg_addr;
                            tcam_data_q <= cfg_data;
                            tcam_mskb_q <= cfg_mskb;
                            tcam_vbe_q  <= 1'b1;
                            tcam_vbi_q  <= 1'b1;
                        end else if (idle_rdy && spk_valid) begin
                            // Key is the spike ID left-aligned; only the ID bits take part.
                            state_q     <= ST_CMP;
                            tcam_mode_q <= MODE_C;
                            tcam_data_q <= Bits'(spk_id) << (Bits - ID_Width);
                            tcam_mskb_q <= ~({Bits{1'b1}} >> ID_Width);
                        end
                    end

                    ST_WR: begin
                        state_q <= ST_IDLE;
                    end

                    ST_CMP: begin
                        state_q <= ST_CMP_WAIT;
                        cnt_q   <= '0;
                    end

                    ST_CMP_WAIT: begin
                        if (cnt_q == CNT_W'(CMP_LAT - 1)) begin
                            hit_vec_q <= tcam_hitline;
                            state_q   <= ST_SCAN;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end

                    ST_SCAN: begin
                        if (!prio_any) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cur_addr_q  <= prio_idx;
                            state_q     <= ST_RD;
                            tcam_mode_q <= MODE_R;
                            tcam_a_q    <= prio_idx;
                        end
                    end

                    ST_RD: begin
                        state_q <= ST_RD_WAIT;
                        cnt_q   <= '0;
                    end

                    ST_RD_WAIT: begin
                        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                            syn_valid_q  <= 1'b1;
                            syn_dst_q    <= tcam_dst;
                            syn_weight_q <= tcam_weight;
                            syn_addr_q   <= cur_addr_q;
                            state_q      <= ST_OUT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end

                    ST_OUT: begin
                        if (syn_ready) begin
                            syn_valid_q           <= 1'b0;
                            hit_vec_q[cur_addr_q] <= 1'b0;
                            state_q               <= ST_SCAN;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tcam_spike_sched.sv
module tb_tcam_spike_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spk_valid, spk_ready;
    logic [3:0]  spk_id;
    logic        cfg_valid, cfg_ready;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_data, cfg_mskb;
    logic        syn_valid, syn_ready;
    logic [3:0]  syn_dst, syn_weight, syn_addr;
    logic [2:0]  tcam_mode;
    logic [7:0]  tcam_data, tcam_mskb;
    logic [3:0]  tcam_a;
    logic        tcam_vbe, tcam_vbi;
    logic [15:0] tcam_hitline;
    logic [3:0]  tcam_dst, tcam_weight;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    tcam_spike_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spk_valid    (spk_valid),
        .spk_ready    (spk_ready),
        .spk_id       (spk_id),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_mskb     (cfg_mskb),
        .syn_valid    (syn_valid),
        .syn_ready    (syn_ready),
        .syn_dst      (syn_dst),
        .syn_weight   (syn_weight),
        .syn_addr     (syn_addr),
        .tcam_mode    (tcam_mode),
        .tcam_data    (tcam_data),
        .tcam_mskb    (tcam_mskb),
        .tcam_a       (tcam_a),
        .tcam_vbe     (tcam_vbe),
        .tcam_vbi     (tcam_vbi),
        .tcam_hitline (tcam_hitline),
        .tcam_dst     (tcam_dst),
        .tcam_weight  (tcam_weight),
        .busy         (busy)
    );

    // Fixed per-entry payload held by the TCAM's companion RAM.
    function automatic logic [3:0] dst_of(input int a);
        return 4'(a) ^ 4'hA;
    endfunction

    function automatic logic [3:0] wt_of(input int a);
        return 4'(a + 3);
    endfunction

    // Behavioural TCAM: results stay on the bus until the next command of that kind.
    logic [7:0]  m_data [16];
    logic [7:0]  m_mskb [16];
    logic [15:0] m_vld;

    always @(posedge clk) begin
        case (tcam_mode)
            3'b001: if (tcam_vbe) begin
                m_data[tcam_a] <= tcam_data;
                m_mskb[tcam_a] <= tcam_mskb;
                m_vld[tcam_a]  <= tcam_vbi;
            end
            3'b100: for (int i = 0; i < 16; i++)
                tcam_hitline[i] <= m_vld[i] && (((m_data[i] ^ tcam_data) & m_mskb[i] & tcam_mskb) == 8'h00);
            3'b010: begin
                tcam_dst    <= dst_of(int'(tcam_a));
                tcam_weight <= wt_of(int'(tcam_a));
            end
            3'b101: begin
                m_vld        <= '0;
                tcam_hitline <= '0;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cfg_wr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
        int n;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = d; cfg_mskb = m;
        n = 0;
        while (!cfg_ready && n < 50) begin @(negedge clk); n++; end
        chk("cfg_rdy", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("wr_mode", tcam_mode, 3'b001);
        chk("wr_a", tcam_a, a);
        chk("wr_data", tcam_data, d);
        chk("wr_mskb", tcam_mskb, m);
        chk("wr_vbe_vbi", {tcam_vbe, tcam_vbi}, 2'b11);
    endtask

    // Returns on the negedge just after the accepting edge (state CMP).
    task automatic spike(input logic [3:0] id);
        int n;
        @(negedge clk);
        spk_valid = 1'b1; spk_id = id;
        n = 0;
        while (!spk_ready && n < 50) begin @(negedge clk); n++; end
        chk("spk_rdy", spk_ready, 1);
        @(negedge clk);
        spk_valid = 1'b0;
        chk("cmp_mode", tcam_mode, 3'b100);
        chk("cmp_data", tcam_data, {id, 4'h0});
        chk("cmp_mskb", tcam_mskb, 8'hF0);
    endtask

    // Starts on the negedge after spike accept. Latency counts edges from the
    // accepting edge to the edge at which syn_valid is first sampled high.
    task automatic collect(input int hold);
        int k, prev, n_ev;
        n_ev = 0; k = 0; prev = 0;
        while (busy && k < 300) begin
            if (syn_valid) begin
                if (n_ev == 0) chk("first_lat", k + 1, 7);
                else chk("gap", k - prev, (n_ev == 1 ? hold : 0) + 4);
                prev = k;
                if (n_ev < exp_q.size()) begin
                    chk("syn_addr", syn_addr, exp_q[n_ev]);
                    chk("syn_dst", syn_dst, dst_of(exp_q[n_ev]));
                    chk("syn_wt", syn_weight, wt_of(exp_q[n_ev]));
                end else begin
                    chk("extra_event", 1, 0);
                end
                if (hold > 0 && n_ev == 0) begin
                    syn_ready = 1'b0;
                    repeat (hold) begin
                        @(negedge clk); k++;
                        chk("hold_vld", syn_valid, 1);
                        chk("hold_addr", syn_addr, exp_q[0]);
                        chk("hold_dst", syn_dst, dst_of(exp_q[0]));
                        chk("hold_no_rd", tcam_mode, 3'b000);
                    end
                    syn_ready = 1'b1;
                end
                n_ev++;
            end
            @(negedge clk); k++;
        end
        chk("busy_done", busy, 0);
        chk("n_events", n_ev, exp_q.size());
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, sv;
        rst_n = 1'b0; spk_valid = 1'b0; spk_id = '0; cfg_valid = 1'b0;
        cfg_addr = '0; cfg_data = '0; cfg_mskb = '0; syn_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mode", tcam_mode, 3'b101);
        chk("rst_busy", busy, 0);
        chk("rst_syn_vld", syn_valid, 0);
        chk("rst_syn_dst", syn_dst, 0);
        chk("rst_tcam_a", tcam_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel1_mode", tcam_mode, 3'b101);
        chk("rel1_rdy", {cfg_ready, spk_ready}, 2'b00);
        @(negedge clk);
        chk("rel2_mode", tcam_mode, 3'b000);
        chk("rel2_rdy", {cfg_ready, spk_ready}, 2'b11);

        // Two entries for ID 5, scanned in ascending order
        cfg_wr(4'd3, 8'h50, 8'hF0);
        cfg_wr(4'd9, 8'h50, 8'hF0);
        spike(4'd5);
        exp_q = '{3, 9};
        collect(0);

        // No match: busy through CMP, 2x CMP_WAIT, SCAN
        spike(4'd7);
        k = 0; sv = 0;
        while (busy && k < 50) begin
            if (syn_valid) sv++;
            @(negedge clk); k++;
        end
        chk("nm_busy_cycles", k, 4);
        chk("nm_no_event", sv, 0);

        // cfg and spike together: cfg first, spike on the next IDLE cycle
        @(negedge clk);
        cfg_valid = 1'b1; cfg_addr = 4'd12; cfg_data = 8'h50; cfg_mskb = 8'hF0;
        spk_valid = 1'b1; spk_id = 4'd5;
        chk("both_rdy", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("both_wr_mode", tcam_mode, 3'b001);
        chk("both_wr_a", tcam_a, 12);
        chk("both_spk_blocked", spk_ready, 0);
        @(negedge clk);
        chk("both_spk_rdy", spk_ready, 1);
        @(negedge clk);
        spk_valid = 1'b0;
        chk("both_cmp_mode", tcam_mode, 3'b100);
        exp_q = '{3, 9, 12};
        collect(0);

        // Output stall for 5 cycles
        spike(4'd5);
        exp_q = '{3, 9, 12};
        collect(5);

        // Reset pulse during RD_WAIT
        spike(4'd5);
        repeat (5) @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_mode", tcam_mode, 3'b000);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mode", tcam_mode, 3'b101);
        chk("mid_rst_vld", syn_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", syn_addr, 0);
        chk("mid_rst_tcam_a", tcam_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel1_mode", tcam_mode, 3'b101);
        chk("mid_rel1_rdy", cfg_ready, 0);
        @(negedge clk);
        chk("mid_rel2_mode", tcam_mode, 3'b000);
        chk("mid_rel2_rdy", cfg_ready, 1);
        sv = 0; k = 0;
        repeat (12) begin
            @(negedge clk);
            if (syn_valid) sv++;
            if (busy) k++;
        end
        chk("mid_no_stale_evt", sv, 0);
        chk("mid_idle", k, 0);

        // All 16 entries match ID 2
        for (int a = 0; a < 16; a++) cfg_wr(4'(a), 8'h20, 8'hF0);
        spike(4'd2);
        for (int a = 0; a < 16; a++) exp_q.push_back(a);
        collect(0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/tcam_spike_sched.md
TCAM_SPIKE_SCHED -- requirements
Module: tcam_spike_sched

Interface
REQ-001 SHALL have parameter ID_Width, default 4, packet/destination ID width.
REQ-002 SHALL have parameter AddressSize, default 4, TCAM address width.
REQ-003 SHALL have parameter Words, default 16, TCAM entries (2**AddressSize).
REQ-004 SHALL have parameter Bits, default 8, TCAM word width.
REQ-005 SHALL have parameter Weight_Width, default 4, synaptic weight width.
REQ-006 SHALL have parameter CMP_LAT, default 2, cycles from compare issue to valid hitline.
REQ-007 SHALL have parameter RD_LAT, default 1, cycles from read issue to valid read data.
REQ-008 SHALL use one clock; reset is asynchronous and active-low, with ports clk and rst_n.
REQ-009 SHALL have the following ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- spk_valid/spk_ready  in/out  1/1  spike handshake
- spk_id  in  ID_Width  fired packet ID
- cfg_valid/cfg_ready  in/out  1/1  entry-program handshake
- cfg_addr  in  AddressSize  entry address
- cfg_data  in  Bits  entry data
- cfg_mskb  in  Bits  entry care mask
- syn_valid/syn_ready  out/in  1/1  synapse-event handshake
- syn_dst  out  ID_Width  destination ID
- syn_weight  out  Weight_Width  weight
- syn_addr  out  AddressSize  matching entry
- tcam_mode  out  3  TCAM mode (I=000, W=001, R=010, C=100, RST=101)
- tcam_data  out  Bits  TCAM data
- tcam_mskb  out  Bits  TCAM mask
- tcam_a  out  AddressSize  TCAM address
- tcam_vbe  out  1  valid-bit enable
- tcam_vbi  out  1  valid-bit input
- tcam_hitline  in  Words  compare hitline
- tcam_dst  in  ID_Width  read destination ID
- tcam_weight  in  Weight_Width  read weight
- busy  out  1  high in any state other than IDLE

Function
REQ-010 SHALL implement FSM states IDLE, WR, CMP, CMP_WAIT, SCAN, RD, RD_WAIT, OUT.
REQ-011 In IDLE, cfg_ready and spk_ready SHALL both be 1; cfg_valid SHALL win over simultaneous spk_valid, and only that handshake completes.
REQ-012 In WR, for exactly one cycle, SHALL drive mode W with a=cfg_addr, data=cfg_data, mskb=cfg_mskb, vbe=1, vbi=1, then return to IDLE.
REQ-013 In CMP, for one cycle, SHALL drive mode C with data={spk_id, zeros} and mskb={ID_Width ones, zeros}.
REQ-014 CMP_WAIT SHALL count CMP_LAT cycles, then capture tcam_hitline into hit_vec and go to SCAN.
REQ-015 In SCAN, if hit_vec is 0 SHALL return to IDLE (no output); otherwise it SHALL select the lowest set index into cur_addr and go to RD.
REQ-016 In RD, for one cycle, SHALL drive mode R with a=cur_addr.
REQ-017 RD_WAIT SHALL count RD_LAT cycles, register tcam_dst/tcam_weight/cur_addr into syn_*, then go to OUT.
REQ-018 In OUT, syn_valid SHALL be 1 and syn_* SHALL stay stable until syn_ready; on handshake, SHALL clear hit_vec[cur_addr] and return to SCAN.
REQ-019 Outside WR/CMP/RD, tcam_mode SHALL be I and all other tcam_* outputs 0.
REQ-020 Per spike, events SHALL be emitted in ascending address order, one per matching entry; all 16 matching SHALL yield 16 events.
REQ-021 Spike-to-first-event latency SHALL be 1+CMP_LAT+1+1+RD_LAT+1 cycles (7 at defaults), with a 3+RD_LAT cycle gap thereafter when syn_ready is held high.
REQ-022 No new spike or cfg SHALL be accepted until the current spike's scan completes.

Reset
REQ-023 While rst_n=0, outputs SHALL be: state IDLE; syn_* 0; busy 0; tcam_mode RST; other tcam_* 0; hit_vec and counters 0.
REQ-024 On the first cycle after reset release, SHALL drive mode RST; normal IDLE behaviour (REQ-011) SHALL begin from the second cycle.
REQ-025 Reset mid-operation SHALL discard the pending hit_vec and any pending output.

Structure
REQ-026 Mode encodings and the FSM state enum SHALL live in shared package tcam_pkg.
REQ-027 Lowest-set-bit selection SHALL be sub-module tcam_prio_enc (Words in -> AddressSize index plus any-hit flag).

Verification
REQ-028 Reset, then cfg writes addr3 data 0x50 mskb 0xF0 and addr9 data 0x50 mskb 0xF0; spike id 5 -> two events, addr 3 then 9, first syn_valid 7 cycles after spike accept.
REQ-029 Spike id 7 with no match -> no syn_valid; busy high 4 cycles then IDLE.
REQ-030 cfg_valid and spk_valid both asserted in the same IDLE cycle -> cfg accepted first; spike accepted next IDLE cycle.
REQ-031 syn_ready held low 5 cycles during OUT -> syn_* held stable, no tcam read issued.
REQ-032 All 16 entries programmed to id 2; spike 2 -> 16 events, addresses 0..15.
REQ-033 rst_n pulsed low during RD_WAIT -> outputs reset values, then tcam_mode RST for 1 cycle, then IDLE with no stale event.
